tile_scan_sequencer: RTL and testbench
======================================

Name: tile_scan_sequencer

Overview:
- Walks a TILES_X x TILES_Y tile grid once per frame and issues each tile's index and base address to the downstream detection engine over a valid/ready handshake.
- After each accepted tile, waits for tile_done before issuing the next tile.
- Owns the row/column scan order and the frame-level start/done/abort control of the tile-offset path.
- For the default 3x3 grid with a 640 stride, the address sequence is 0, 1, 2, 640, 641, 642, 1280, 1281, 1282.

Parameters:
- TILES_X, 3, tiles per row (>=1)
- TILES_Y, 3, tile rows per frame (>=1)
- ROW_STRIDE, 640, address increment between tile rows
- ADDR_W, 11, tile_addr width; arithmetic wraps mod 2^ADDR_W
- IDX_W, 4, tile_idx width; must hold TILES_X*TILES_Y-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; sampled only in IDLE
- abort  in  1  synchronous frame abort; any state
- tile_ready  in  1  downstream accepts the offered tile
- tile_done  in  1  downstream finished the current tile (1-cycle pulse)
- tile_valid  out  1  tile_idx/tile_addr are valid
- tile_idx  out  IDX_W  linear tile number, row*TILES_X+col
- tile_addr  out  ADDR_W  tile base, row*ROW_STRIDE+col
- busy  out  1  high whenever the state is not IDLE
- frame_done  out  1  1-cycle pulse after the last tile's tile_done

Behaviour:
- Reset (rst_n low, async): state IDLE, row=col=0; tile_valid, busy, frame_done = 0; tile_idx = 0; tile_addr = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - start=1 -> ISSUE at the next edge with row=col=0.
  - Result: tile_valid=1, tile_idx=0, tile_addr=0 one cycle after start.
- ISSUE:
  - tile_valid held at 1; idx and addr held stable until tile_valid&&tile_ready.
  - On that handshake -> WAIT_DONE and tile_valid=0 at the next edge.
  - tile_done is ignored in ISSUE.
- WAIT_DONE, on tile_done:
  - Not the last tile: advance col (col==TILES_X-1 -> col=0, row+1) and go to ISSUE. The next tile is valid the cycle after tile_done.
  - Last tile (row==TILES_Y-1 and col==TILES_X-1): go to IDLE, pulse frame_done=1 for exactly one cycle, and busy=0 in that same cycle.
- Address generation is incremental, with no multiplier:
  - row_base register += ROW_STRIDE per row.
  - tile_addr = row_base + col, truncated to ADDR_W.
  - tile_idx increments by 1 per tile.
- abort=1 in any non-IDLE state:
  - Go to IDLE next edge; tile_valid=0; counters cleared; frame_done not pulsed.
  - abort wins over a simultaneous tile_ready or tile_done.
  - abort in IDLE: no effect, and it overrides a simultaneous start.
- start while busy: ignored; no restart or requeue.
- start in the same cycle frame_done is asserted: accepted, since the state is already IDLE. The new frame's tile 0 is valid on the next cycle.
- TILES_X=1 or TILES_Y=1: degenerate scans behave per the same rules. 1x1 gives one tile, then frame_done.

Optional Feature:
- Macro: TILE_SCAN_SERPENTINE_EN.
- Defined:
  - Odd rows scan right-to-left (col from TILES_X-1 down to 0).
  - tile_addr and tile_idx follow the actual col.
  - Default 3x3 address order: 0,1,2,642,641,640,1280,1281,1282.
  - Last tile is row TILES_Y-1 at col 0 if TILES_Y is even, otherwise at col TILES_X-1.
- Not defined: raster order only; serpentine logic is absent.

Test Plan:
- Reset then start pulse, tile_ready tied 1, tile_done 3 cycles after each accept:
  - tile_addr sequence is 0,1,2,640,641,642,1280,1281,1282 and tile_idx is 0..8.
  - Exactly one frame_done pulse, coincident with busy falling.
- tile_ready held low 5 cycles at tile 4: tile_valid stays 1 with tile_addr=641 and tile_idx=4 throughout; no advance until ready.
- abort asserted during WAIT_DONE of tile 5:
  - Next cycle busy=0, tile_valid=0, no frame_done.
  - A following start restarts at tile_addr=0.
- start during busy, and tile_done during ISSUE: both ignored; the sequence is unchanged.
- rst_n dropped asynchronously mid-frame (between clock edges): outputs zero immediately; after release, start gives tile_addr=0.
- TILE_SCAN_SERPENTINE_EN defined, default parameters: address order 0,1,2,642,641,640,1280,1281,1282; frame_done after tile_idx 8.

Source files
------------

// File: rtl/tile_scan_sequencer.sv
// Tile-grid scan sequencer: offers each tile's index/base address over valid/ready, waits for tile_done.
// Optional boustrophedon order (odd rows right-to-left) when TILE_SCAN_SERPENTINE_EN is defined.
module tile_scan_sequencer #(
    parameter int TILES_X    = 3,
    parameter int TILES_Y    = 3,
    parameter int ROW_STRIDE = 640,
    parameter int ADDR_W     = 11,
    parameter int IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              tile_ready,
    input  logic              tile_done,
    output logic              tile_valid,
    output logic [IDX_W-1:0]  tile_idx,
    output logic [ADDR_W-1:0] tile_addr,
    output logic              busy,
    output logic              frame_done
);

    // state     | meaning
    // IDLE      | no frame in progress, waiting for start
    // ISSUE     | tile offered, waiting for tile_ready
    // WAIT_DONE | tile accepted, waiting for tile_done
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    localparam int COL_W = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int ROW_W = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam logic [COL_W-1:0]  COL_MAX = COL_W'(TILES_X - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(TILES_Y - 1);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(ROW_STRIDE);
    localparam logic [IDX_W-1:0]  IDX_ROW = IDX_W'(TILES_X);
`ifdef TILE_SCAN_SERPENTINE_EN
    localparam logic [COL_W-1:0]  LAST_COL = (TILES_Y % 2 == 0) ? '0 : COL_MAX;
`else
    localparam logic [COL_W-1:0]  LAST_COL = COL_MAX;
`endif

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row, row_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic [ADDR_W-1:0]  row_base, row_base_nxt;
    logic [IDX_W-1:0]   idx_base, idx_base_nxt;
    logic               frame_done_nxt;
    logic               last_tile;

    assign last_tile = (row == ROW_MAX) && (col == LAST_COL);

    always_comb begin
        state_nxt      = state;
        row_nxt        = row;
        col_nxt        = col;
        row_base_nxt   = row_base;
        idx_base_nxt   = idx_base;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt    = ISSUE;
                    row_nxt      = '0;
                    col_nxt      = '0;
                    row_base_nxt = '0;
                    idx_base_nxt = '0;
                end
            end
            ISSUE: begin
                if (tile_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tile_done) begin
                    if (last_tile) begin
                        state_nxt      = IDLE;
                        frame_done_nxt = 1'b1;
                        row_nxt        = '0;
                        col_nxt        = '0;
                        row_base_nxt   = '0;
                        idx_base_nxt   = '0;
                    end else begin
                        state_nxt = ISSUE;
`ifdef TILE_SCAN_SERPENTINE_EN
                        // Row change keeps col; the scan direction flips with row parity.
                        if (row[0]) begin
                            if (col == '0) begin
                                row_nxt      = row + 1'b1;
                                row_base_nxt = row_base + STRIDE;
                                idx_base_nxt = idx_base + IDX_ROW;
                            end else begin
                                col_nxt = col - 1'b1;
                            end
                        end else begin
                            if (col == COL_MAX) begin
                                row_nxt      = row + 1'b1;
                                row_base_nxt = row_base + STRIDE;
                                idx_base_nxt = idx_base + IDX_ROW;
                            end else begin
                                col_nxt = col + 1'b1;
                            end
                        end
`else
                        if (col == COL_MAX) begin
                            col_nxt      = '0;
                            row_nxt      = row + 1'b1;
                            row_base_nxt = row_base + STRIDE;
                            idx_base_nxt = idx_base + IDX_ROW;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt      = IDLE;
            frame_done_nxt = 1'b0;
            row_nxt        = '0;
            col_nxt        = '0;
            row_base_nxt   = '0;
            idx_base_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            row_base   <= '0;
            idx_base   <= '0;
            tile_valid <= 1'b0;
            tile_idx   <= '0;
            tile_addr  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            row_base   <= row_base_nxt;
            idx_base   <= idx_base_nxt;
            tile_valid <= (state_nxt == ISSUE);
            tile_idx   <= idx_base_nxt + IDX_W'(col_nxt);
            tile_addr  <= row_base_nxt + ADDR_W'(col_nxt);
            busy       <= (state_nxt != IDLE);
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_tile_scan_sequencer.sv
// Directed bench for tile_scan_sequencer, default 3x3 grid with 640 stride.
// Expected order tables switch when TILE_SCAN_SERPENTINE_EN is defined.
module tb_tile_scan_sequencer;
    localparam int AW = 11;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tile_ready = 1'b1;
    logic          tile_done = 1'b0;
    logic          tile_valid;
    logic [IW-1:0] tile_idx;
    logic [AW-1:0] tile_addr;
    logic          busy;
    logic          frame_done;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int exp_addr [9];
    int exp_idx  [9];

    tile_scan_sequencer #(
        .TILES_X(3), .TILES_Y(3), .ROW_STRIDE(640), .ADDR_W(AW), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .tile_ready(tile_ready), .tile_done(tile_done),
        .tile_valid(tile_valid), .tile_idx(tile_idx), .tile_addr(tile_addr),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for an offer, then check its contents.
    task automatic check_offer(input int k);
        int n = 0;
        while (tile_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check($sformatf("offer%0d_valid", k), {31'b0, tile_valid}, 32'd1);
        check($sformatf("offer%0d_idx", k), {28'b0, tile_idx}, exp_idx[k]);
        check($sformatf("offer%0d_addr", k), {21'b0, tile_addr}, exp_addr[k]);
        check($sformatf("offer%0d_busy", k), {31'b0, busy}, 32'd1);
    endtask

    // tile_ready is high: accept next edge, then tile_done three cycles after the accept.
    task automatic finish_tile(input int k);
        step();
        check($sformatf("wait%0d_valid", k), {31'b0, tile_valid}, 32'd0);
        step();
        step();
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        if (k != 8) check($sformatf("tile%0d_no_fdone", k), {31'b0, frame_done}, 32'd0);
    endtask

    task automatic run_tiles(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            check_offer(k);
            finish_tile(k);
        end
    endtask

    initial begin
`ifdef TILE_SCAN_SERPENTINE_EN
        exp_addr = '{0, 1, 2, 642, 641, 640, 1280, 1281, 1282};
        exp_idx  = '{0, 1, 2, 5, 4, 3, 6, 7, 8};
`else
        exp_addr = '{0, 1, 2, 640, 641, 642, 1280, 1281, 1282};
        exp_idx  = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
`endif
        #2;
        check("rst_valid", {31'b0, tile_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_fdone", {31'b0, frame_done}, 32'd0);
        check("rst_idx", {28'b0, tile_idx}, 32'd0);
        check("rst_addr", {21'b0, tile_addr}, 32'd0);
        #10 rst_n = 1'b1;
        step();

        // Frame 1: stall at tile 4, with ignored tile_done and start during ISSUE.
        start = 1'b1;
        step();
        start = 1'b0;
        run_tiles(0, 3);
        check_offer(4);
        tile_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                tile_done = 1'b1;
                start = 1'b1;
            end
            step();
            tile_done = 1'b0;
            start = 1'b0;
            check($sformatf("stall%0d_valid", i), {31'b0, tile_valid}, 32'd1);
            check($sformatf("stall%0d_addr", i), {21'b0, tile_addr}, exp_addr[4]);
            check($sformatf("stall%0d_idx", i), {28'b0, tile_idx}, exp_idx[4]);
        end
        tile_ready = 1'b1;
        finish_tile(4);
        run_tiles(5, 8);
        check("f1_fdone", {31'b0, frame_done}, 32'd1);
        check("f1_busy_low", {31'b0, busy}, 32'd0);
        check("f1_valid_low", {31'b0, tile_valid}, 32'd0);

        // Start coincident with frame_done is accepted.
        start = 1'b1;
        step();
        start = 1'b0;
        check("f1_fdone_pulse_end", {31'b0, frame_done}, 32'd0);
        check("f2_immediate_valid", {31'b0, tile_valid}, 32'd1);
        check_offer(0);
        finish_tile(0);
        run_tiles(1, 4);

        // Abort during WAIT_DONE of tile 5, together with tile_done.
        check_offer(5);
        step();
        check("f2_wait5_valid", {31'b0, tile_valid}, 32'd0);
        step();
        abort = 1'b1;
        tile_done = 1'b1;
        step();
        abort = 1'b0;
        tile_done = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_valid", {31'b0, tile_valid}, 32'd0);
        check("abort_fdone", {31'b0, frame_done}, 32'd0);
        step();
        check("abort_fdone_later", {31'b0, frame_done}, 32'd0);

        // Abort in IDLE overrides start.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", {31'b0, busy}, 32'd0);
        check("idle_abort_valid", {31'b0, tile_valid}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_offer(0);
        run_tiles(0, 2);

        // Asynchronous reset between clock edges during WAIT_DONE of tile 3.
        check_offer(3);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, tile_valid}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_idx", {28'b0, tile_idx}, 32'd0);
        check("arst_addr", {21'b0, tile_addr}, 32'd0);
        #3 rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_tiles(0, 8);
        check("f4_fdone", {31'b0, frame_done}, 32'd1);
        check("f4_busy_low", {31'b0, busy}, 32'd0);
        step();
        check("f4_fdone_end", {31'b0, frame_done}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
